message_schedule: RTL and testbench



---
 rtl/message_schedule.sv | 95 +++++++++
 tb/tb_message_schedule.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[t] and pairs it
// with the round constant K[t], issuing one (W, K) pair per clock.
module message_schedule #(
  parameter int WK_LENGTH = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [511:0] message_block,
  output logic [31:0]  cur_w,
  output logic [31:0]  cur_k,
  output logic         wk_valid,
  output logic [5:0]   wk_index,
  output logic         wk_index_complete,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] LAST_IDX = 6'(WK_LENGTH - 1);

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t             state_q, state_d;
  logic [15:0][31:0]  win_q, win_d;
  logic [5:0]         idx_q, idx_d;
  logic               cmpl_q, cmpl_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      cmpl_q  <= cmpl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    cmpl_d  = cmpl_q;
    case (state_q)
      RUN: begin
        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
        // Index freezes on the last pair so wk_index keeps showing it in DONE.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cmpl_d  = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: begin
        if (load) begin
          for (int i = 0; i < 16; i++) win_d[i] = message_block[511 - 32*i -: 32];
          idx_d   = '0;
          cmpl_d  = 1'b0;
          state_d = RUN;
        end
      end
    endcase
  end

  assign busy              = (state_q == RUN);
  assign wk_valid          = busy;
  assign cur_w             = busy ? win_q[0] : 32'h0;
  assign cur_k             = busy ? K_ROM[idx_q] : 32'h0;
  assign wk_index          = idx_q;
  assign wk_index_complete = cmpl_q;

endmodule

// File: tb/tb_message_schedule.sv
// Self-checking bench for message_schedule: fixed vectors, a behavioural
// SHA-256 schedule model, and multi-cycle corner sequences.
module tb_message_schedule;

  logic         clock = 1'b0, reset = 1'b1;
  logic         load = 1'b0, load16 = 1'b0;
  logic [511:0] block = '0, block16 = '0;
  logic [31:0]  cur_w, cur_k, cur_w16, cur_k16;
  logic         wk_valid, wk_cmpl, busy, wk_valid16, wk_cmpl16, busy16;
  logic [5:0]   wk_index, wk_index16;

  always #5 clock = ~clock;

  message_schedule #(.WK_LENGTH(64)) dut (
    .clock(clock), .reset(reset), .load(load), .message_block(block),
    .cur_w(cur_w), .cur_k(cur_k), .wk_valid(wk_valid), .wk_index(wk_index),
    .wk_index_complete(wk_cmpl), .busy(busy));

  message_schedule #(.WK_LENGTH(16)) dut16 (
    .clock(clock), .reset(reset), .load(load16), .message_block(block16),
    .cur_w(cur_w16), .cur_k(cur_k16), .wk_valid(wk_valid16), .wk_index(wk_index16),
    .wk_index_complete(wk_cmpl16), .busy(busy16));

  int n_cmp = 0, n_err = 0;

  logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] exp_w [64];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];

  typedef struct {
    int          t;
    logic        cw;
    logic [31:0] w;
    logic [31:0] k;
  } vec_t;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-word schedule straight from the recurrence on a flat array.
  task automatic calc(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rnd_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Load b, then check all 64 pairs and the DONE entry. If inj_t >= 0, drive
  // a load of ib during pair inj_t; it must be ignored.
  task automatic stream(input logic [511:0] b, input int inj_t, input logic [511:0] ib, input string nm);
    calc(b);
    load = 1'b1; block = b;
    tick();
    for (int t = 0; t < 64; t++) begin
      load = (t == inj_t);
      if (t == inj_t) block = ib;
      cap_w[t] = cur_w;
      cap_k[t] = cur_k;
      chk({nm, ".w"}, cur_w, exp_w[t]);
      chk({nm, ".k"}, cur_k, KT[t]);
      chk({nm, ".idx"}, {26'h0, wk_index}, t);
      chk({nm, ".valid"}, {31'h0, wk_valid}, 32'd1);
      chk({nm, ".busy"}, {31'h0, busy}, 32'd1);
      chk({nm, ".cmpl_run"}, {31'h0, wk_cmpl}, 32'd0);
      tick();
    end
    load = 1'b0;
    chk({nm, ".done_valid"}, {31'h0, wk_valid}, 32'd0);
    chk({nm, ".done_cmpl"}, {31'h0, wk_cmpl}, 32'd1);
    chk({nm, ".done_busy"}, {31'h0, busy}, 32'd0);
    chk({nm, ".done_w"}, cur_w, 32'd0);
    chk({nm, ".done_k"}, cur_k, 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{t: 0,  cw: 1'b1, w: 32'h61626380, k: 32'h428a2f98};
    tbl[1] = '{t: 15, cw: 1'b1, w: 32'h00000018, k: 32'hc19bf174};
    tbl[2] = '{t: 16, cw: 1'b1, w: 32'h61626380, k: 32'he49b69c1};
    tbl[3] = '{t: 17, cw: 1'b1, w: 32'h000f0000, k: 32'hefbe4786};
    tbl[4] = '{t: 1,  cw: 1'b1, w: 32'h00000000, k: 32'h71374491};
    tbl[5] = '{t: 63, cw: 1'b0, w: 32'h00000000, k: 32'hc67178f2};

    // Reset state
    tick(); tick();
    chk("rst.w", cur_w, 0);
    chk("rst.k", cur_k, 0);
    chk("rst.valid", {31'h0, wk_valid}, 0);
    chk("rst.idx", {26'h0, wk_index}, 0);
    chk("rst.cmpl", {31'h0, wk_cmpl}, 0);
    chk("rst.busy", {31'h0, busy}, 0);
    reset = 1'b0;
    tick();
    chk("idle.busy", {31'h0, busy}, 0);

    // "abc" block, then fixed-vector table against the captured stream
    stream(ABC, -1, '0, "abc");
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].cw) chk($sformatf("abc_tbl.w%0d", tbl[i].t), cap_w[tbl[i].t], tbl[i].w);
      chk($sformatf("abc_tbl.k%0d", tbl[i].t), cap_k[tbl[i].t], tbl[i].k);
    end
    tick();

    // All-zero block
    stream('0, -1, '0, "zero");
    tick(); tick();

    // Random blocks against the model
    for (int r = 0; r < 3; r++) begin
      stream(rnd_block(), -1, '0, $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Load during RUN at t=10 is ignored
    stream(rnd_block(), 10, rnd_block(), "ign");
    tick();

    // Back-to-back: abc loaded on the first DONE cycle
    stream(rnd_block(), -1, '0, "btbA");
    stream(ABC, -1, '0, "btbB");

    // Reset mid-RUN at t=30
    tick();
    calc(ABC);
    load = 1'b1; block = ABC;
    tick();
    load = 1'b0;
    repeat (30) tick();
    chk("mid.w30", cur_w, exp_w[30]);
    chk("mid.idx30", {26'h0, wk_index}, 30);
    #2 reset = 1'b1;
    #1;
    chk("mid.rst_w", cur_w, 0);
    chk("mid.rst_k", cur_k, 0);
    chk("mid.rst_valid", {31'h0, wk_valid}, 0);
    chk("mid.rst_idx", {26'h0, wk_index}, 0);
    chk("mid.rst_cmpl", {31'h0, wk_cmpl}, 0);
    chk("mid.rst_busy", {31'h0, busy}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid.idle_busy", {31'h0, busy}, 0);
    stream(ABC, -1, '0, "mid_abc");

    // WK_LENGTH = 16 instance
    calc(ABC);
    load16 = 1'b1; block16 = ABC;
    tick();
    load16 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      chk("l16.w", cur_w16, exp_w[t]);
      chk("l16.k", cur_k16, KT[t]);
      chk("l16.idx", {26'h0, wk_index16}, t);
      chk("l16.valid", {31'h0, wk_valid16}, 1);
      chk("l16.cmpl_run", {31'h0, wk_cmpl16}, 0);
      tick();
    end
    chk("l16.done_valid", {31'h0, wk_valid16}, 0);
    chk("l16.done_cmpl", {31'h0, wk_cmpl16}, 1);
    chk("l16.done_busy", {31'h0, busy16}, 0);
    tick();
    chk("l16.hold_cmpl", {31'h0, wk_cmpl16}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
